// File: rtl/program_executor_pkg.sv
// Shared opcode and state definitions for the program executor and its instruction ROM.
package program_executor_pkg;

  localparam logic [4:0] OP_CLEARLD = 5'd0;
  localparam logic [4:0] OP_ADDLD   = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SHTR    = 5'd3;
  localparam logic [4:0] OP_DISP    = 5'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/program_executor_if.sv
// Instruction ROM bus: the executor drives the address, the ROM returns func/value combinationally.
interface program_executor_if;
  logic [4:0] selector;
  logic [4:0] func;
  logic [4:0] value;

  modport master (output selector, input func, input value);
  modport slave  (input selector, output func, output value);
endinterface

// File: rtl/program_executor_alu.sv
// Combinational instruction datapath: next R0/R1/carry and an illegal-opcode flag.
module program_executor_alu
  import program_executor_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [4:0]        func,
  input  logic [DATA_W-1:0] r0,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] zval,
  input  logic              carry,
  output logic [DATA_W-1:0] r0_n,
  output logic [DATA_W-1:0] r1_n,
  output logic              carry_n,
  output logic              illegal
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum     = {1'b0, r0} + {1'b0, r1};
    r0_n    = r0;
    r1_n    = r1;
    carry_n = carry;
    illegal = 1'b0;
    case (func)
      OP_CLEARLD: begin
        r0_n = zval;
        r1_n = '0;
      end
      OP_ADDLD: r1_n = zval;
      OP_ADD: begin
        r0_n    = sum[DATA_W-1:0];
        carry_n = sum[DATA_W];
      end
      OP_SHTR: r0_n = r0 >> 1;
      OP_DISP: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_executor.sv
// Program sequencer: steps the ROM address, executes one instruction per FETCH/EXEC pair, halts at PROG_LEN.
module program_executor
  import program_executor_pkg::*;
#(
  parameter int PROG_LEN = 5,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  program_executor_if.master  rom,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                carry,
  output logic                disp_valid,
  output logic [DATA_W-1:0]   disp_data
);

  localparam logic [4:0] LAST_SEL = 5'(PROG_LEN - 1);

  state_t            state_q, state_n;
  logic [4:0]        sel_q, sel_n;
  logic [DATA_W-1:0] r0_q, r0_n, r1_q, r1_n, ddata_q, ddata_n;
  logic              carry_q, carry_n, dvalid_q, dvalid_n;

  logic [DATA_W-1:0] alu_r0, alu_r1;
  logic              alu_carry, alu_illegal;

  program_executor_alu #(.DATA_W(DATA_W)) u_alu (
    .func    (rom.func),
    .r0      (r0_q),
    .r1      (r1_q),
    .zval    (DATA_W'(rom.value)),
    .carry   (carry_q),
    .r0_n    (alu_r0),
    .r1_n    (alu_r1),
    .carry_n (alu_carry),
    .illegal (alu_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
      ddata_q  <= '0;
      carry_q  <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      sel_q    <= sel_n;
      r0_q     <= r0_n;
      r1_q     <= r1_n;
      ddata_q  <= ddata_n;
      carry_q  <= carry_n;
      dvalid_q <= dvalid_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    sel_n    = sel_q;
    r0_n     = r0_q;
    r1_n     = r1_q;
    carry_n  = carry_q;
    ddata_n  = ddata_q;
    dvalid_n = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_n = ST_FETCH;
          sel_n   = '0;
          r0_n    = '0;
          r1_n    = '0;
          carry_n = 1'b0;
        end
      end
      ST_FETCH: state_n = ST_EXEC;
      ST_EXEC: begin
        if (alu_illegal) begin
          state_n = ST_ERROR;
        end else begin
          r0_n    = alu_r0;
          r1_n    = alu_r1;
          carry_n = alu_carry;
          if (rom.func == OP_DISP) begin
            ddata_n  = r0_q;
            dvalid_n = 1'b1;
          end
          // Termination by compare, so the address never wraps.
          if (sel_q == LAST_SEL) begin
            state_n = ST_DONE;
          end else begin
            sel_n   = sel_q + 5'd1;
            state_n = ST_FETCH;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign rom.selector = sel_q;
  assign busy         = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERROR);
  assign carry        = carry_q;
  assign disp_valid   = dvalid_q;
  assign disp_data    = ddata_q;

endmodule

// File: tb/tb_program_executor.sv
// Bench: ROM program tables drive two executors; DISP results are checked through per-DUT scoreboards.
module tb_program_executor;
  import program_executor_pkg::*;

  typedef struct packed {
    logic [4:0] func;
    logic [4:0] value;
    logic       disp;
    logic [7:0] exp_data;
    logic       exp_carry;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_a, start_b;
  logic       busy_a, done_a, error_a, carry_a, dv_a;
  logic [7:0] dd_a;
  logic       busy_b, done_b, error_b, carry_b, dv_b;
  logic [4:0] dd_b;

  program_executor_if rif_a ();
  program_executor_if rif_b ();

  vec_t prog_a [32];
  vec_t prog_b [32];
  exp_t qa[$], qb[$];
  exp_t ea, eb;

  int n_chk = 0;
  int n_fail = 0;

  always_comb begin
    rif_a.func  = prog_a[rif_a.selector].func;
    rif_a.value = prog_a[rif_a.selector].value;
    rif_b.func  = prog_b[rif_b.selector].func;
    rif_b.value = prog_b[rif_b.selector].value;
  end

  program_executor #(.PROG_LEN(5), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rom(rif_a),
    .busy(busy_a), .done(done_a), .error(error_a), .carry(carry_a),
    .disp_valid(dv_a), .disp_data(dd_a)
  );

  program_executor #(.PROG_LEN(18), .DATA_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rom(rif_b),
    .busy(busy_b), .done(done_b), .error(error_b), .carry(carry_b),
    .disp_valid(dv_b), .disp_data(dd_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dv_a) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL disp_a_unexpected: got pulse data %0h expected no pulse", dd_a);
      end else begin
        ea = qa.pop_front();
        chk("disp_a_data", 32'(dd_a), 32'(ea.data));
        chk("disp_a_carry", 32'(carry_a), 32'(ea.carry));
      end
    end
    if (rst_n && dv_b) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL disp_b_unexpected: got pulse data %0h expected no pulse", dd_b);
      end else begin
        eb = qb.pop_front();
        chk("disp_b_data", 32'(dd_b), 32'(eb.data));
        chk("disp_b_carry", 32'(carry_b), 32'(eb.carry));
      end
    end
  end

  task automatic push_a();
    for (int i = 0; i < 5; i++)
      if (prog_a[i].disp) qa.push_back('{data: prog_a[i].exp_data, carry: prog_a[i].exp_carry});
  endtask

  task automatic pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  // Full run on DUT A with selector/status trace; glitch_k re-asserts start mid-run.
  task automatic run_a(input int glitch_k);
    push_a();
    pulse_a();
    for (int k = 0; k < 10; k++) begin
      chk("sel_a_trace", 32'(rif_a.selector), 32'(k / 2));
      chk("status_a_busy", {busy_a, done_a, error_a}, 3'b100);
      if (k == glitch_k) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("status_a_done", {busy_a, done_a, error_a}, 3'b010);
    chk("sel_a_hold", 32'(rif_a.selector), 32'd4);
    @(negedge clk);
    chk("qa_empty", qa.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    for (int i = 0; i < 32; i++) begin
      prog_a[i] = '0;
      prog_b[i] = '0;
    end
    prog_a[0] = '{OP_CLEARLD, 5'd5, 1'b0, 8'd0, 1'b0};
    prog_a[1] = '{OP_ADDLD,   5'd3, 1'b0, 8'd0, 1'b0};
    prog_a[2] = '{OP_ADD,     5'd0, 1'b0, 8'd0, 1'b0};
    prog_a[3] = '{OP_SHTR,    5'd0, 1'b0, 8'd0, 1'b0};
    prog_a[4] = '{OP_DISP,    5'd0, 1'b1, 8'd4, 1'b0};
    prog_b[0] = '{OP_CLEARLD, 5'd31, 1'b0, 8'd0, 1'b0};
    prog_b[1] = '{OP_ADDLD,   5'd31, 1'b0, 8'd0, 1'b0};
    for (int j = 0; j < 8; j++) begin
      prog_b[2 + 2 * j] = '{OP_ADD,  5'd0, 1'b0, 8'd0, 1'b0};
      prog_b[3 + 2 * j] = '{OP_DISP, 5'd0, 1'b1, 8'(30 - j), 1'b1};
    end

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    #1;
    chk("reset_a_outputs", {rif_a.selector, busy_a, done_a, error_a, carry_a, dv_a, dd_a}, '0);
    chk("reset_b_outputs", {rif_b.selector, busy_b, done_b, error_b, carry_b, dv_b, dd_b}, '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_without_start", {busy_a, done_a, error_a}, 3'b000);

    // Basic run, then back-to-back run from DONE.
    run_a(-1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_between_runs", {dd_a, dv_a, done_a}, {8'd4, 1'b0, 1'b1});
    end
    run_a(-1);

    // Restart requests during FETCH and EXEC must not disturb the run.
    run_a(3);
    run_a(6);

    // Illegal opcode at address 2.
    prog_a[2].func = 5'd7;
    pulse_a();
    repeat (6) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("error_status", {busy_a, done_a, error_a}, 3'b001);
      chk("error_sel", 32'(rif_a.selector), 32'd2);
      @(negedge clk);
    end
    prog_a[2].func = OP_ADD;
    run_a(-1);

    // Wrapping ADD chain on the 5-bit instance.
    for (int i = 0; i < 18; i++)
      if (prog_b[i].disp) qb.push_back('{data: prog_b[i].exp_data, carry: prog_b[i].exp_carry});
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    c = 0;
    while (!done_b && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("run_b_cycles", c, 36);
    @(negedge clk);
    chk("qb_empty", qb.size(), 0);
    chk("carry_b_final", 32'(carry_b), 32'd1);
    chk("error_b", 32'(error_b), 32'd0);

    // Asynchronous reset while EXEC of ADD is in progress.
    pulse_a();
    repeat (5) @(negedge clk);
    chk("pre_reset_sel", 32'(rif_a.selector), 32'd2);
    chk("pre_reset_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_a", {rif_a.selector, busy_a, done_a, error_a, carry_a, dv_a, dd_a}, '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_after_reset", {rif_a.selector, busy_a, done_a, error_a, dv_a}, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
